// File: rtl/ibex_rf_write_sched_if.sv
// Writeback request and RF write-port bundle for ibex_rf_write_sched.
// The slave modport is taken by the scheduler, and the master modport by its surroundings.
interface ibex_rf_write_sched_if #(
   parameter int unsigned DataWidth = 32
) ();
   logic                 init_req_i;
   logic                 init_done_o;
   logic                 ex_valid_i;
   logic [4:0]           ex_addr_i;
   logic [DataWidth-1:0] ex_data_i;
   logic                 ex_ready_o;
   logic                 lsu_valid_i;
   logic [4:0]           lsu_addr_i;
   logic [DataWidth-1:0] lsu_data_i;
   logic                 lsu_ready_o;
   logic                 dummy_instr_i;
   logic                 rf_we_o;
   logic [4:0]           rf_waddr_o;
   logic [DataWidth-1:0] rf_wdata_o;

   modport master (
      output init_req_i, ex_valid_i, ex_addr_i, ex_data_i,
             lsu_valid_i, lsu_addr_i, lsu_data_i, dummy_instr_i,
      input  init_done_o, ex_ready_o, lsu_ready_o,
             rf_we_o, rf_waddr_o, rf_wdata_o
   );

   modport slave (
      input  init_req_i, ex_valid_i, ex_addr_i, ex_data_i,
             lsu_valid_i, lsu_addr_i, lsu_data_i, dummy_instr_i,
      output init_done_o, ex_ready_o, lsu_ready_o,
             rf_we_o, rf_waddr_o, rf_wdata_o
   );
endinterface

// File: rtl/ibex_rf_write_sched.sv
// RF write-port scheduler. After reset it scrubs every writable word, because latch words have no reset.
// It then arbitrates EX and LSU writeback onto the single write port, with fixed priority and an anti-starvation override.
module ibex_rf_write_sched #(
   parameter int unsigned          RV32E       = 0,
   parameter int unsigned          DataWidth   = 32,
   parameter logic [DataWidth-1:0] WordZeroVal = '0,
   parameter int unsigned          MaxStall    = 4
) (
   input logic                  clk_i,
   input logic                  rst_i,
   ibex_rf_write_sched_if.slave bus
);
   localparam int unsigned NumWords = (RV32E != 0) ? 16 : 32;
   localparam logic [4:0]  LastAddr = 5'(NumWords - 1);
   localparam logic [3:0]  StallMax = 4'(MaxStall);

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   state_e               state_q;
   logic [4:0]           cnt_q;
   logic [3:0]           stall_q;
   logic                 rf_we_q;
   logic [4:0]           rf_waddr_q;
   logic [DataWidth-1:0] rf_wdata_q;

   logic       ex_prio;
   logic       ex_ready;
   logic       lsu_ready;
   logic       ex_acc;
   logic       lsu_acc;
   logic [4:0] ex_addr;
   logic [4:0] lsu_addr;

   always_comb begin
      ex_prio   = (stall_q == StallMax);
      lsu_ready = (state_q == RUN) && !ex_prio;
      ex_ready  = (state_q == RUN) && (!bus.lsu_valid_i || ex_prio);
      ex_acc    = bus.ex_valid_i && ex_ready;
      lsu_acc   = bus.lsu_valid_i && lsu_ready;
      // On RV32E the upper address bit is discarded before the x0 check.
      ex_addr   = (RV32E != 0) ? {1'b0, bus.ex_addr_i[3:0]}  : bus.ex_addr_i;
      lsu_addr  = (RV32E != 0) ? {1'b0, bus.lsu_addr_i[3:0]} : bus.lsu_addr_i;
   end

   assign bus.ex_ready_o  = ex_ready;
   assign bus.lsu_ready_o = lsu_ready;
   assign bus.init_done_o = (state_q == RUN);
   assign bus.rf_we_o     = rf_we_q;
   assign bus.rf_waddr_o  = rf_waddr_q;
   assign bus.rf_wdata_o  = rf_wdata_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= INIT;
         cnt_q      <= 5'd1;
         stall_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= WordZeroVal;
      end else begin
         unique case (state_q)
            INIT: begin
               stall_q    <= '0;
               rf_wdata_q <= WordZeroVal;
               if (bus.init_req_i) begin
                  cnt_q      <= 5'd1;
                  rf_we_q    <= 1'b0;
                  rf_waddr_q <= '0;
               end else begin
                  rf_we_q    <= 1'b1;
                  rf_waddr_q <= cnt_q;
                  cnt_q      <= cnt_q + 5'd1;
                  if (cnt_q == LastAddr) begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               rf_we_q    <= 1'b0;
               rf_waddr_q <= '0;
               rf_wdata_q <= WordZeroVal;
               // An x0 target completes the handshake but writes nothing, unless a dummy instruction issued it from EX.
               if (ex_acc) begin
                  if (ex_addr != '0 || bus.dummy_instr_i) begin
                     rf_we_q    <= 1'b1;
                     rf_waddr_q <= ex_addr;
                     rf_wdata_q <= bus.ex_data_i;
                  end
               end else if (lsu_acc && lsu_addr != '0) begin
                  rf_we_q    <= 1'b1;
                  rf_waddr_q <= lsu_addr;
                  rf_wdata_q <= bus.lsu_data_i;
               end
               if (bus.ex_valid_i && !ex_ready) begin
                  if (stall_q != StallMax) begin
                     stall_q <= stall_q + 4'd1;
                  end
               end else begin
                  stall_q <= '0;
               end
               if (bus.init_req_i) begin
                  state_q <= INIT;
                  cnt_q   <= 5'd1;
                  stall_q <= '0;
               end
            end
            default: state_q <= INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_ibex_rf_write_sched.sv
// Directed bench for ibex_rf_write_sched: a scrub sequence, a table of arbitration vectors, and init/reset/RV32E corner sequences.
module tb_ibex_rf_write_sched;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic rst_e = 1'b1;
   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk_i = ~clk_i;

   ibex_rf_write_sched_if #(.DataWidth(32)) bus   ();
   ibex_rf_write_sched_if #(.DataWidth(32)) bus_e ();

   ibex_rf_write_sched #(.RV32E(0), .DataWidth(32), .MaxStall(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
   );
   ibex_rf_write_sched #(.RV32E(1), .DataWidth(32), .MaxStall(4)) dut_e (
      .clk_i(clk_i), .rst_i(rst_e), .bus(bus_e)
   );

   typedef struct {
      logic        ex_v;
      logic [4:0]  ex_a;
      logic [31:0] ex_d;
      logic        lsu_v;
      logic [4:0]  lsu_a;
      logic [31:0] lsu_d;
      logic        dummy;
      logic        exp_exr;
      logic        exp_lsr;
      logic        exp_we;
      logic [4:0]  exp_wa;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   function automatic vec_t mk(input logic ex_v, input logic [4:0] ex_a, input logic [31:0] ex_d,
                               input logic lsu_v, input logic [4:0] lsu_a, input logic [31:0] lsu_d,
                               input logic dummy, input logic exr, input logic lsr,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd);
      vec_t v;
      v.ex_v = ex_v; v.ex_a = ex_a; v.ex_d = ex_d;
      v.lsu_v = lsu_v; v.lsu_a = lsu_a; v.lsu_d = lsu_d; v.dummy = dummy;
      v.exp_exr = exr; v.exp_lsr = lsr; v.exp_we = we; v.exp_wa = wa; v.exp_wd = wd;
      return v;
   endfunction

   task automatic idle_inputs();
      bus.init_req_i = 0; bus.ex_valid_i = 0; bus.ex_addr_i = '0; bus.ex_data_i = '0;
      bus.lsu_valid_i = 0; bus.lsu_addr_i = '0; bus.lsu_data_i = '0; bus.dummy_instr_i = 0;
      bus_e.init_req_i = 0; bus_e.ex_valid_i = 0; bus_e.ex_addr_i = '0; bus_e.ex_data_i = '0;
      bus_e.lsu_valid_i = 0; bus_e.lsu_addr_i = '0; bus_e.lsu_data_i = '0; bus_e.dummy_instr_i = 0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      idle_inputs();

      // Reset state, then the scrub on both variants in parallel.
      repeat (2) @(negedge clk_i);
      check("rst_we", bus.rf_we_o, 0);
      check("rst_waddr", bus.rf_waddr_o, 0);
      check("rst_wdata", bus.rf_wdata_o, 0);
      check("rst_done", bus.init_done_o, 0);
      check("rst_exr", bus.ex_ready_o, 0);
      check("rst_lsr", bus.lsu_ready_o, 0);
      check("rst_e_we", bus_e.rf_we_o, 0);
      rst_i = 0;
      rst_e = 0;
      for (int i = 1; i <= 31; i++) begin
         tick();
         check("scrub_we", bus.rf_we_o, 1);
         check("scrub_waddr", bus.rf_waddr_o, 32'(i));
         check("scrub_wdata", bus.rf_wdata_o, 0);
         check("scrub_done", bus.init_done_o, 32'(i == 31));
         if (i < 31) begin
            check("scrub_exr", bus.ex_ready_o, 0);
            check("scrub_lsr", bus.lsu_ready_o, 0);
         end
         if (i <= 15) begin
            check("e_scrub_we", bus_e.rf_we_o, 1);
            check("e_scrub_waddr", bus_e.rf_waddr_o, 32'(i));
            check("e_scrub_done", bus_e.init_done_o, 32'(i == 15));
         end else if (i == 16) begin
            check("e_scrub_end_we", bus_e.rf_we_o, 0);
            check("e_scrub_end_done", bus_e.init_done_o, 1);
         end
      end
      tick();
      check("scrub_end_we", bus.rf_we_o, 0);
      check("scrub_end_done", bus.init_done_o, 1);

      // Arbitration table: inputs for cycle N, readies in cycle N, rf_* in cycle N+1.
      vecs.push_back(mk(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 1, 5'd5, 32'hDEADBEEF));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 5'd0, 32'h55, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 5'd0, 32'h1234, 0, 0, 0, 1, 1, 1, 1, 5'd0, 32'h1234));
      vecs.push_back(mk(0, 0, 0, 1, 5'd0, 32'h99, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 5'd9, 32'hA5A5, 0, 0, 1, 1, 5'd9, 32'hA5A5));
      vecs.push_back(mk(1, 5'd31, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 1, 1, 5'd31, 32'hFFFFFFFF));
      // Both valid: four LSU wins, then one forced EX win, twice over.
      for (int k = 0; k < 10; k++) begin
         if (k % 5 == 4)
            vecs.push_back(mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 1, 0, 1, 5'd3, 32'h33));
         else
            vecs.push_back(mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 1, 1, 5'd4, 32'h44));
      end
      // Dropping ex_valid clears the stall count, so four LSU wins are needed again.
      vecs.push_back(mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 1, 1, 5'd4, 32'h44));
      vecs.push_back(mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 1, 1, 5'd4, 32'h44));
      vecs.push_back(mk(0, 5'd3, 32'h33, 1, 5'd6, 32'h66, 0, 0, 1, 1, 5'd6, 32'h66));
      for (int k = 0; k < 5; k++) begin
         if (k == 4)
            vecs.push_back(mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 1, 0, 1, 5'd3, 32'h33));
         else
            vecs.push_back(mk(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0, 1, 1, 5'd4, 32'h44));
      end

      foreach (vecs[i]) begin
         bus.ex_valid_i = vecs[i].ex_v; bus.ex_addr_i = vecs[i].ex_a; bus.ex_data_i = vecs[i].ex_d;
         bus.lsu_valid_i = vecs[i].lsu_v; bus.lsu_addr_i = vecs[i].lsu_a; bus.lsu_data_i = vecs[i].lsu_d;
         bus.dummy_instr_i = vecs[i].dummy;
         #1;
         check($sformatf("v%0d_exr", i), bus.ex_ready_o, vecs[i].exp_exr);
         check($sformatf("v%0d_lsr", i), bus.lsu_ready_o, vecs[i].exp_lsr);
         tick();
         check($sformatf("v%0d_we", i), bus.rf_we_o, vecs[i].exp_we);
         if (vecs[i].exp_we) begin
            check($sformatf("v%0d_waddr", i), bus.rf_waddr_o, 32'(vecs[i].exp_wa));
            check($sformatf("v%0d_wdata", i), bus.rf_wdata_o, vecs[i].exp_wd);
         end
      end
      idle_inputs();
      tick();

      // init_req in RUN alongside an accepted EX write, then a reset in the middle of the scrub.
      bus.ex_valid_i = 1; bus.ex_addr_i = 5'd7; bus.ex_data_i = 32'h77; bus.init_req_i = 1;
      #1;
      check("ireq_exr", bus.ex_ready_o, 1);
      tick();
      idle_inputs();
      check("ireq_we", bus.rf_we_o, 1);
      check("ireq_waddr", bus.rf_waddr_o, 7);
      check("ireq_wdata", bus.rf_wdata_o, 32'h77);
      check("ireq_done", bus.init_done_o, 0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         check("rescrub_we", bus.rf_we_o, 1);
         check("rescrub_waddr", bus.rf_waddr_o, 32'(i));
      end
      rst_i = 1;
      tick();
      rst_i = 0;
      check("midrst_we", bus.rf_we_o, 0);
      check("midrst_waddr", bus.rf_waddr_o, 0);
      check("midrst_done", bus.init_done_o, 0);
      for (int i = 1; i <= 31; i++) begin
         tick();
         check("restart_we", bus.rf_we_o, 1);
         check("restart_waddr", bus.rf_waddr_o, 32'(i));
      end
      tick();
      check("restart_end_we", bus.rf_we_o, 0);
      check("restart_end_done", bus.init_done_o, 1);

      // RV32E: the upper address bit is ignored, so 5'h10 aliases x0 and is dropped.
      bus_e.ex_valid_i = 1; bus_e.ex_addr_i = 5'h13; bus_e.ex_data_i = 32'hABCD;
      #1;
      check("e_exr", bus_e.ex_ready_o, 1);
      tick();
      check("e_we", bus_e.rf_we_o, 1);
      check("e_waddr", bus_e.rf_waddr_o, 3);
      check("e_wdata", bus_e.rf_wdata_o, 32'hABCD);
      bus_e.ex_addr_i = 5'h10; bus_e.ex_data_i = 32'h1;
      tick();
      check("e_x0_we", bus_e.rf_we_o, 0);
      idle_inputs();
      tick();
      check("e_idle_we", bus_e.rf_we_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
